// File: rtl/primitive_fetch_arbiter_pkg.sv
// Shared types and default sizing for the primitive fetch arbiter.
// Enum names and the unit size are the ones the SurfaceUnit side uses.
package primitive_fetch_arbiter_pkg;

    localparam int AABB_TEST_UNIT_SIZE = 4;
    localparam int PRIM_FETCH_UNIT     = AABB_TEST_UNIT_SIZE;

    localparam int PFA_NUM_REQ = 4;
    localparam int PFA_IDX_W   = 16;
    localparam int PFA_DATA_W  = 512;
    localparam int PFA_MEM_LAT = 2;

    typedef struct packed {
        logic [PFA_IDX_W-1:0] start_index;
        logic [PFA_IDX_W-1:0] end_index;
    } prim_query_t;

    typedef enum logic [1:0] {
        PFA_IDLE  = 2'd0,
        PFA_ISSUE = 2'd1,
        PFA_DRAIN = 2'd2
    } pfa_state_e;

endpackage

// File: rtl/primitive_fetch_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req high,
// searching upward from rr_ptr and wrapping at NUM_REQ.
module primitive_fetch_arbiter_rr_pick
    import primitive_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = PFA_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] cand;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        any  = 1'b0;
        id   = '0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[cand]) begin
                any = 1'b1;
                id  = cand;
            end
        end
    end

endmodule

// File: rtl/primitive_fetch_arbiter.sv
// Shares one fixed-latency primitive read port between NUM_REQ surface units,
// bursting UNIT-wide groups per granted range and tagging returns with the owner.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  PFA_IDLE  | pick next requester round-robin, latch range, issue first beat
//  PFA_ISSUE | one read beat per cycle until the range is covered
//  PFA_DRAIN | hold the port until all tags retire and the minimum gap elapses
module primitive_fetch_arbiter
    import primitive_fetch_arbiter_pkg::*;
#(
    parameter int NUM_REQ = PFA_NUM_REQ,
    parameter int IDX_W   = PFA_IDX_W,
    parameter int UNIT    = PRIM_FETCH_UNIT,
    parameter int DATA_W  = PFA_DATA_W,
    parameter int MEM_LAT = PFA_MEM_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*IDX_W-1:0]   req_start,
    input  logic [NUM_REQ*IDX_W-1:0]   req_end,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       mem_rd,
    output logic [IDX_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_last,
    output logic [DATA_W-1:0]          rsp_data
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CUR_W = IDX_W + 1;
    localparam int TMR_W = $clog2(MEM_LAT + 1);
    localparam int FL_W  = $clog2(MEM_LAT + 2);

    pfa_state_e       state;
    logic [CUR_W-1:0] cur;
    logic [CUR_W-1:0] end_r;
    logic [ID_W-1:0]  id_r;
    logic [ID_W-1:0]  rr_ptr;
    logic [TMR_W-1:0] timer;
    logic [FL_W-1:0]  inflight;

    // Tag travelling with the registered strobe, then MEM_LAT shift stages;
    // the last stage lines up with mem_rdata.
    logic             rd_last;
    logic [ID_W-1:0]  rd_id;
    logic             pipe_vld  [1:MEM_LAT];
    logic             pipe_last [1:MEM_LAT];
    logic [ID_W-1:0]  pipe_id   [1:MEM_LAT];

    logic             pick_any;
    logic [ID_W-1:0]  pick_id;
    logic [CUR_W-1:0] pick_start;
    logic [CUR_W-1:0] pick_end;
    logic [CUR_W-1:0] beat_base;
    logic [CUR_W-1:0] beat_lim;
    logic [CUR_W-1:0] beat_next;
    logic [ID_W-1:0]  beat_id;
    logic             beat_ok;
    logic             beat_last;
    logic             issue;

    primitive_fetch_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .any    (pick_any),
        .id     (pick_id)
    );

    // The first beat is issued straight out of IDLE so it lands with grant.
    always_comb begin
        pick_start = {1'b0, req_start[int'(pick_id)*IDX_W +: IDX_W]};
        pick_end   = {1'b0, req_end[int'(pick_id)*IDX_W +: IDX_W]};
        if (state == PFA_IDLE) begin
            beat_base = pick_start;
            beat_lim  = pick_end;
            beat_id   = pick_id;
        end else begin
            beat_base = cur;
            beat_lim  = end_r;
            beat_id   = id_r;
        end
        beat_next = beat_base + CUR_W'(UNIT);
        beat_ok   = beat_base < beat_lim;
        beat_last = beat_next >= beat_lim;
        issue     = beat_ok && ((state == PFA_IDLE && pick_any) || state == PFA_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PFA_IDLE;
            cur       <= '0;
            end_r     <= '0;
            id_r      <= '0;
            rr_ptr    <= '0;
            timer     <= '0;
            inflight  <= '0;
            rd_last   <= 1'b0;
            rd_id     <= '0;
            for (int s = 1; s <= MEM_LAT; s++) begin
                pipe_vld[s]  <= 1'b0;
                pipe_last[s] <= 1'b0;
                pipe_id[s]   <= '0;
            end
            grant     <= '0;
            done      <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
        end else begin
            done   <= '0;
            mem_rd <= issue;
            if (issue) begin
                mem_addr <= beat_base[IDX_W-1:0];
                cur      <= beat_next;
                rd_id    <= beat_id;
                rd_last  <= beat_last;
            end

            pipe_vld[1]  <= mem_rd;
            pipe_last[1] <= rd_last;
            pipe_id[1]   <= rd_id;
            for (int s = 2; s <= MEM_LAT; s++) begin
                pipe_vld[s]  <= pipe_vld[s-1];
                pipe_last[s] <= pipe_last[s-1];
                pipe_id[s]   <= pipe_id[s-1];
            end
            inflight <= inflight + FL_W'(issue) - FL_W'(pipe_vld[MEM_LAT]);

            rsp_valid <= pipe_vld[MEM_LAT];
            rsp_last  <= pipe_vld[MEM_LAT] && pipe_last[MEM_LAT];
            if (pipe_vld[MEM_LAT]) begin
                rsp_id   <= pipe_id[MEM_LAT];
                rsp_data <= mem_rdata;
            end

            case (state)
                PFA_IDLE: begin
                    if (pick_any) begin
                        grant <= NUM_REQ'(1) << pick_id;
                        id_r  <= pick_id;
                        end_r <= pick_end;
                        if (!issue) begin
                            cur <= pick_start;
                        end
                        if (issue && beat_last) begin
                            state <= PFA_DRAIN;
                            timer <= TMR_W'(MEM_LAT);
                        end else begin
                            state <= PFA_ISSUE;
                        end
                    end
                end
                PFA_ISSUE: begin
                    if (!beat_ok || beat_last) begin
                        state <= PFA_DRAIN;
                        timer <= TMR_W'(MEM_LAT);
                    end
                end
                PFA_DRAIN: begin
                    // Timer enforces the gap even for an empty range.
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (inflight == '0) begin
                        done   <= NUM_REQ'(1) << id_r;
                        grant  <= '0;
                        rr_ptr <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + 1'b1;
                        state  <= PFA_IDLE;
                    end
                end
                default: state <= PFA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_primitive_fetch_arbiter.sv
// Directed bench for primitive_fetch_arbiter with a delayed-memory model
// and a scoreboard of expected response beats.
module tb_primitive_fetch_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 16;
    localparam int UNIT    = 4;
    localparam int DATA_W  = 512;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic [1:0]  id;
        logic        last;
        logic [15:0] addr;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*IDX_W-1:0] req_start;
    logic [NUM_REQ*IDX_W-1:0] req_end;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     mem_rd;
    logic [IDX_W-1:0]         mem_addr;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic                     rsp_last;
    logic [DATA_W-1:0]        rsp_data;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    logic             m_v1, m_v2;
    logic [IDX_W-1:0] m_a1, m_a2;

    logic [10:0] t1_exp [1:7];
    logic [15:0] t1_addr [1:3];

    primitive_fetch_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W),
        .UNIT    (UNIT),
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_start (req_start),
        .req_end   (req_end),
        .grant     (grant),
        .done      (done),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [15:0] a);
        return {32{a ^ 16'h5a5a}};
    endfunction

    // Memory answers exactly MEM_LAT cycles after the strobe; junk otherwise.
    always @(posedge clk) begin
        m_v1 <= mem_rd;
        m_a1 <= mem_addr;
        m_v2 <= m_v1;
        m_a2 <= m_a1;
    end
    assign mem_rdata = (m_v2 === 1'b1) ? mk_data(m_a2) : {16{32'hdeadbeef}};

    // Scoreboard consumer and per-cycle grant sanity.
    always @(negedge clk) begin
        exp_t x;
        if (reset === 1'b0) begin
            checks++;
            assert ($onehot0(grant)) else begin
                errors++;
                $error("FAIL grant_onehot: observed=%b expected=at most one bit", grant);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected: observed id=%0d last=%0d expected=no beat", rsp_id, rsp_last);
                end
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    checks++;
                    assert ({rsp_id, rsp_last} === {x.id, x.last}) else begin
                        errors++;
                        $error("FAIL rsp_tag: observed id=%0d last=%0d expected id=%0d last=%0d",
                               rsp_id, rsp_last, x.id, x.last);
                    end
                    checks++;
                    assert (rsp_data === mk_data(x.addr)) else begin
                        errors++;
                        $error("FAIL rsp_data: observed=%0h expected beat of addr %0d",
                               rsp_data[31:0], x.addr);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_range(input int id, input int s, input int e);
        req_start[id*IDX_W +: IDX_W] = IDX_W'(s);
        req_end[id*IDX_W +: IDX_W]   = IDX_W'(e);
    endtask

    task automatic push_range(input int id, input int s, input int e);
        exp_t x;
        for (int a = s; a < e; a += UNIT) begin
            x.id   = 2'(id);
            x.last = (a + UNIT >= e);
            x.addr = 16'(a);
            sb.push_back(x);
        end
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        int n = 0;
        while (grant == '0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp);
        int n = 0;
        while (done == '0 && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=still running expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d1, m3;
        bit done3;

        // {grant, done, mem_rd, rsp_valid, rsp_last} for the single-range burst
        t1_exp[1] = {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0};
        t1_exp[2] = {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0};
        t1_exp[3] = {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0};
        t1_exp[4] = {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        t1_exp[5] = {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0};
        t1_exp[6] = {4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
        t1_exp[7] = {4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
        t1_addr[1] = 16'd0;
        t1_addr[2] = 16'd4;
        t1_addr[3] = 16'd8;

        reset     = 1'b1;
        req       = '0;
        req_start = '0;
        req_end   = '0;
        tick();
        tick();
        chk("reset_ctrl", 32'({grant, done, mem_rd, rsp_valid, rsp_last, rsp_id}), 32'd0);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_data", 32'(rsp_data != '0), 32'd0);
        reset = 1'b0;
        tick();

        // Round-robin across all four, then requester 0 again.
        for (int k = 0; k < 4; k++) set_range(k, 0, 4);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) push_range(k, 0, 4);
        for (int k = 0; k < 4; k++) begin
            wait_grant($sformatf("rr_grant%0d", k), 4'(1 << k));
            wait_done($sformatf("rr_done%0d", k), 4'(1 << k));
            req[k] = 1'b0;
            if (k == 3) begin
                req[0] = 1'b1;
                push_range(0, 0, 4);
            end
        end
        wait_grant("rr_regrant0", 4'b0001);
        wait_done("rr_redone0", 4'b0001);
        req[0] = 1'b0;
        tick();

        // Single range [0,10): exact cycle timing.
        set_range(0, 0, 10);
        push_range(0, 0, 10);
        req[0] = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("single_c%0d", c), 32'({grant, done, mem_rd, rsp_valid, rsp_last}), 32'(t1_exp[c]));
            if (c <= 3) chk($sformatf("single_addr_c%0d", c), 32'(mem_addr), 32'(t1_addr[c]));
            if (c == 7) req[0] = 1'b0;
        end
        tick();

        // Empty range: grant, no beats, done after 3+MEM_LAT cycles.
        set_range(2, 20, 20);
        req[2] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("empty_c%0d", c), 32'({grant, done, mem_rd, rsp_valid}),
                32'({(c < 5) ? 4'b0100 : 4'b0000, (c == 5) ? 4'b0100 : 4'b0000, 1'b0, 1'b0}));
            if (c == 5) req[2] = 1'b0;
        end
        tick();

        // Reset while the second of five beats is in flight.
        set_range(2, 0, 20);
        req[2] = 1'b1;
        tick();
        tick();
        tick();
        chk("rstmid_beat3", 32'({mem_rd, mem_addr}), 32'({1'b1, 16'd8}));
        reset = 1'b1;
        sb.delete();
        tick();
        chk("rstmid_outs", 32'({grant, done, mem_rd, rsp_valid, rsp_last, mem_addr}), 32'd0);
        reset = 1'b0;
        req   = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rstmid_quiet%0d", c), 32'({grant, done, mem_rd, rsp_valid}), 32'd0);
        end
        set_range(0, 0, 4);
        set_range(3, 0, 4);
        push_range(0, 0, 4);
        push_range(3, 0, 4);
        req = 4'b1001;
        wait_grant("rstmid_grant0", 4'b0001);
        wait_done("rstmid_done0", 4'b0001);
        req[0] = 1'b0;
        wait_grant("rstmid_grant3", 4'b1000);
        wait_done("rstmid_done3", 4'b1000);
        req[3] = 1'b0;
        tick();

        // Contention: requester 3 waits for requester 1's burst to finish.
        set_range(1, 0, 16);
        set_range(3, 100, 108);
        push_range(1, 0, 16);
        req[1] = 1'b1;
        d1    = -1;
        m3    = -1;
        done3 = 1'b0;
        for (int c = 1; c <= 60 && !done3; c++) begin
            tick();
            if (c == 2) begin
                req[3] = 1'b1;
                push_range(3, 100, 108);
            end
            if (d1 < 0 && done == '0) chk($sformatf("cont_hold_c%0d", c), 32'(grant), 32'(4'b0010));
            if (done[1]) begin
                d1     = c;
                req[1] = 1'b0;
            end
            if (mem_rd && grant[3] && m3 < 0) m3 = c;
            if (done[3]) begin
                done3  = 1'b1;
                req[3] = 1'b0;
            end
        end
        chk("cont_done1_cycle", 32'(d1), 32'd8);
        chk("cont_gap", 32'(m3 - d1), 32'd1);
        chk("cont_done3", 32'(done3), 32'd1);
        tick();

        // Top of the index space: cur must not wrap.
        set_range(0, 65530, 65535);
        push_range(0, 65530, 65535);
        req[0] = 1'b1;
        tick();
        chk("wrap_beat0", 32'({mem_rd, mem_addr}), 32'({1'b1, 16'd65530}));
        tick();
        chk("wrap_beat1", 32'({mem_rd, mem_addr}), 32'({1'b1, 16'd65534}));
        tick();
        chk("wrap_stop", 32'(mem_rd), 32'd0);
        wait_done("wrap_done", 4'b0001);
        req[0] = 1'b0;
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
